// File: rtl/rf_ctx_ctrl.sv
// Register-file context save/restore initiator.
// Streams R0..R(NREGS-1) out of read port 1, or back in through the write port.
module rf_ctx_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              save,
    input  logic              restore,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err_ctx,
    output logic [SEL_W-1:0]  rf_rdsel,
    input  logic [DATA_W-1:0] rf_rddata,
    output logic [SEL_W-1:0]  rf_wrsel,
    output logic [DATA_W-1:0] rf_wrdata,
    output logic              rf_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE,
        DONE
    } state_t;

    localparam logic [SEL_W:0] LAST = (SEL_W+1)'(NREGS - 1);
    localparam logic [SEL_W:0] ONE  = (SEL_W+1)'(1);

    state_t         state_q;
    logic [SEL_W:0] idx_q;
    logic           err_q;
    logic           out_fire;

    assign busy      = (state_q == SAVE) || (state_q == RESTORE);
    assign done      = (state_q == DONE);
    assign err_ctx   = err_q;

    // abort suppresses any handshake in the cycle it is seen
    assign out_valid = (state_q == SAVE) && !abort;
    assign in_ready  = (state_q == RESTORE) && !abort;
    assign rf_write  = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign rf_rdsel  = idx_q[SEL_W-1:0];
    assign rf_wrsel  = idx_q[SEL_W-1:0];
    assign out_data  = rf_rddata;
    assign rf_wrdata = in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    err_q <= save && restore;
                    if (save && !restore) begin
                        state_q <= SAVE;
                    end else if (restore && !save) begin
                        state_q <= RESTORE;
                    end
                end
                SAVE: begin
                    err_q <= save || restore;
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (out_fire) begin
                        idx_q <= idx_q + ONE;
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                RESTORE: begin
                    err_q <= save || restore;
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (rf_write) begin
                        idx_q <= idx_q + ONE;
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_ctx_ctrl.sv
// Self-checking bench for rf_ctx_ctrl with a behavioural 8x16 register file.
// Save words are scoreboarded; restores are checked by reading the rf model back.
module tb_rf_ctx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        save = 1'b0;
    logic        restore = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        err_ctx;
    logic [2:0]  rf_rdsel;
    logic [15:0] rf_rddata;
    logic [2:0]  rf_wrsel;
    logic [15:0] rf_wrdata;
    logic        rf_write;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;

    rf_ctx_ctrl #(.DATA_W(16), .NREGS(8), .SEL_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .save     (save),
        .restore  (restore),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err_ctx  (err_ctx),
        .rf_rdsel (rf_rdsel),
        .rf_rddata(rf_rddata),
        .rf_wrsel (rf_wrsel),
        .rf_wrdata(rf_wrdata),
        .rf_write (rf_write),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data)
    );

    always #5 clk = ~clk;

    logic [15:0] rf [8];
    logic        init = 1'b0;
    assign rf_rddata = rf[rf_rdsel];

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h1000 + 16'(i);
        end else if (rf_write) begin
            rf[rf_wrsel] <= rf_wrdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] sb[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    int          first_acc = 0;
    int          last_acc = 0;
    int          done_cyc = 0;
    logic        done_busy = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_busy = busy;
            end
            if (err_ctx) err_cnt++;
            if (rf_write) begin
                wr_cnt++;
                chk("write_without_valid", 32'(in_valid), 32'd1);
            end
            if (out_valid && prev_stall) chk("stall_hold", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_save_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("save_word", 32'(out_data), 32'(sb.pop_front()));
                end
                if (acc_cnt == 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        chk("done_timeout", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic push_regs();
        for (int i = 0; i < 8; i++) sb.push_back(rf[i]);
    endtask

    typedef struct {
        logic sv;
        logic rs;
        logic ab;
        logic e_err;
        logic e_busy;
        logic e_ov;
        logic e_ir;
    } vec_t;

    vec_t vt[6];

    initial begin
        int c;
        int d0;
        int e0;
        int k;
        logic acc;
        logic [15:0] pre[8];
        logic pat[4];

        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        // reset state
        init = 1'b1;
        in_data = 16'h5A5A;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_ctx), 32'd0);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rdsel", 32'(rf_rdsel), 32'd0);
        chk("rst_wrsel", 32'(rf_wrsel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h1000);
        chk("rst_wrdata", 32'(rf_wrdata), 32'h5A5A);
        init = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // single-cycle command table from IDLE
        for (int i = 0; i < 6; i++) begin
            save = vt[i].sv;
            restore = vt[i].rs;
            abort = vt[i].ab;
            step();
            save = 1'b0;
            restore = 1'b0;
            abort = 1'b0;
            #1;
            chk($sformatf("tbl%0d_err", i), 32'(err_ctx), 32'(vt[i].e_err));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
            abort = 1'b1;
            step();
            abort = 1'b0;
            step();
            chk($sformatf("tbl%0d_back_idle", i), 32'(busy), 32'd0);
        end

        // 1: full-rate save
        out_ready = 1'b1;
        acc_cnt = 0;
        d0 = done_cnt;
        push_regs();
        save = 1'b1;
        c = cyc;
        step();
        save = 1'b0;
        wait_done(d0, 40);
        chk("t1_words", 32'(acc_cnt), 32'd8);
        chk("t1_first_cycle", 32'(first_acc), 32'(c + 1));
        chk("t1_last_cycle", 32'(last_acc), 32'(c + 8));
        chk("t1_done_cycle", 32'(done_cyc), 32'(c + 9));
        chk("t1_busy_at_done", 32'(done_busy), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        step();

        // 2: save with out_ready 1,0,0,1 pattern
        acc_cnt = 0;
        d0 = done_cnt;
        push_regs();
        save = 1'b1;
        step();
        save = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 100) begin
            out_ready = pat[k % 4];
            step();
            k++;
        end
        chk("t2_done_seen", 32'(done_cnt), 32'(d0 + 1));
        chk("t2_words", 32'(acc_cnt), 32'd8);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
        step();

        // 3: restore with in_valid gaps
        d0 = done_cnt;
        wr_cnt = 0;
        restore = 1'b1;
        step();
        restore = 1'b0;
        k = 0;
        for (int t = 0; t < 60 && k < 8; t++) begin
            in_valid = (t % 3) != 1;
            in_data = 16'hA5A0 + 16'(k);
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc) k++;
        end
        in_valid = 1'b0;
        wait_done(d0, 10);
        step();
        step();
        chk("t3_writes", 32'(wr_cnt), 32'd8);
        chk("t3_done_once", 32'(done_cnt), 32'(d0 + 1));
        for (int i = 0; i < 8; i++) chk($sformatf("t3_R%0d", i), 32'(rf[i]), 32'hA5A0 + 32'(i));

        // 4: save during restore is rejected, restore completes
        d0 = done_cnt;
        e0 = err_cnt;
        restore = 1'b1;
        step();
        restore = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 8; t++) begin
            in_data = 16'h00B0 + 16'(t);
            save = (t == 2);
            step();
            if (t == 2) begin
                chk("t4_err_pulse", 32'(err_ctx), 32'd1);
                chk("t4_still_busy", 32'(busy), 32'd1);
            end
        end
        save = 1'b0;
        in_valid = 1'b0;
        wait_done(d0, 5);
        step();
        chk("t4_err_once", 32'(err_cnt), 32'(e0 + 1));
        for (int i = 0; i < 8; i++) chk($sformatf("t4_R%0d", i), 32'(rf[i]), 32'h00B0 + 32'(i));

        // 5: abort after three save words, then restart
        acc_cnt = 0;
        d0 = done_cnt;
        push_regs();
        save = 1'b1;
        step();
        save = 1'b0;
        step();
        step();
        step();
        chk("t5_three_words", 32'(acc_cnt), 32'd3);
        abort = 1'b1;
        #1;
        chk("t5_abort_no_valid", 32'(out_valid), 32'd0);
        step();
        abort = 1'b0;
        chk("t5_idle_after_abort", 32'(busy), 32'd0);
        chk("t5_out_valid_low", 32'(out_valid), 32'd0);
        sb.delete();
        step();
        step();
        chk("t5_no_done", 32'(done_cnt), 32'(d0));
        acc_cnt = 0;
        push_regs();
        save = 1'b1;
        step();
        save = 1'b0;
        chk("t5_restart_R0", 32'(rf_rdsel), 32'd0);
        wait_done(d0, 40);
        chk("t5_restart_words", 32'(acc_cnt), 32'd8);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        step();

        // 6: async reset after four restore writes
        for (int i = 0; i < 8; i++) pre[i] = rf[i];
        d0 = done_cnt;
        restore = 1'b1;
        step();
        restore = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            in_data = 16'h00C0 + 16'(t);
            step();
        end
        in_data = 16'h00C4;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rf_write", 32'(rf_write), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        chk("t6_wrsel", 32'(rf_wrsel), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk($sformatf("t6_R%0d", i), 32'(rf[i]), 32'h00C0 + 32'(i));
        for (int i = 4; i < 8; i++) chk($sformatf("t6_R%0d", i), 32'(rf[i]), 32'(pre[i]));
        rst_n = 1'b1;
        step();
        step();
        chk("t6_no_done", 32'(done_cnt), 32'(d0));
        chk("t6_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
